// File: rtl/npu_out_serializer.sv
// npu_out_serializer
// Buffers wide NPU result entries (MAC_OUT_NUM lanes) in a small FIFO and
// streams each entry out as two half-width beats under valid/ready
// handshaking. Entries that arrive while the FIFO is full are dropped and
// flagged through a sticky overflow bit.
module npu_out_serializer #(
    parameter int MAC_OUT_NUM = 18,
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_LANES   = 9,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [MAC_OUT_NUM*DATA_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    output logic [OUT_LANES*DATA_WIDTH-1:0]   out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic [$clog2(FIFO_DEPTH):0]       level,
    output logic                              overflow,
    input  logic                              ovf_clr,
    output logic [15:0]                       entry_cnt
);

    localparam int IN_W   = MAC_OUT_NUM * DATA_WIDTH;
    localparam int BEAT_W = OUT_LANES * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

    logic [IN_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             sel;
    logic [IN_W-1:0]  head;
    logic             full;
    logic             accept;
    logic             pop;
    logic             push;
    logic             drop;

    // Handshake qualifiers; out_valid depends only on the level register.
    assign out_valid = (level != '0);
    assign full      = (level == FULL_LVL);
    assign accept    = out_valid && out_ready;
    assign pop       = accept && sel;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;
    // sel is 0 whenever the FIFO is empty, so it doubles as out_last.
    assign out_last  = sel;

    // Output beat mux: selects half of the head entry, zero when idle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        head     = mem[rd_ptr];
        out_data = '0;
        if (out_valid) begin
            out_data = sel ? head[IN_W-1:BEAT_W] : head[BEAT_W-1:0];
        end
    end

    // Entry storage: written on every accepted push.
    // NOTE: the storage array is deliberately left out of reset; pointers and level decide what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, level, beat select, overflow flag and transmitted-entry counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            sel       <= 1'b0;
            overflow  <= 1'b0;
            entry_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                entry_cnt <= entry_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
            if (accept) begin
                sel <= ~sel;
            end
            // A drop in the same cycle wins over a clear request.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_npu_out_serializer.sv
// tb_npu_out_serializer
// Drives directed and random traffic into npu_out_serializer and compares
// every output each cycle with a queue-based model of the serializer.
module tb_npu_out_serializer;

    localparam int MAC_OUT_NUM = 18;
    localparam int DATA_WIDTH  = 8;
    localparam int OUT_LANES   = 9;
    localparam int FIFO_DEPTH  = 4;
    localparam int IN_W        = MAC_OUT_NUM * DATA_WIDTH;
    localparam int BEAT_W      = OUT_LANES * DATA_WIDTH;
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic [BEAT_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              ovf_clr;
    logic [15:0]       entry_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: stored entries, current beat, flag, counter.
    logic [IN_W-1:0] q[$];
    int              m_beat;
    bit              m_ovf;
    int              m_cnt;

    npu_out_serializer #(
        .MAC_OUT_NUM(MAC_OUT_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_LANES  (OUT_LANES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .entry_cnt(entry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] rand_entry();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[IN_W-1:0];
    endfunction

    task automatic compare_all(input string tag);
        logic [IN_W-1:0]   e;
        logic [BEAT_W-1:0] exp_data;
        bit                exp_valid;
        exp_valid = (q.size() != 0);
        exp_data  = '0;
        if (exp_valid) begin
            e        = q[0];
            exp_data = e[m_beat*BEAT_W +: BEAT_W];
        end
        check({tag, ".valid"}, IN_W'(out_valid), IN_W'(exp_valid));
        check({tag, ".data"},  IN_W'(out_data),  IN_W'(exp_data));
        check({tag, ".last"},  IN_W'(out_last),  IN_W'(exp_valid && m_beat == 1));
        check({tag, ".level"}, IN_W'(level),     IN_W'(q.size()));
        check({tag, ".ovf"},   IN_W'(overflow),  IN_W'(m_ovf));
        check({tag, ".cnt"},   IN_W'(entry_cnt), IN_W'(m_cnt));
    endtask

    // Model of one clock edge from the specification's rules.
    task automatic model_edge(input bit v, input logic [IN_W-1:0] d, input bit r, input bit c);
        bit acc, pp, fl, dr;
        acc = (q.size() != 0) && r;
        pp  = acc && (m_beat == 1);
        fl  = (q.size() == FIFO_DEPTH);
        dr  = v && fl && !pp;
        if (pp) begin
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (acc) m_beat = pp ? 0 : 1;
        if (v && !dr) q.push_back(d);
        if (dr) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    // Apply inputs, check outputs before the edge, then advance one cycle.
    task automatic step(input string tag, input bit v, input logic [IN_W-1:0] d, input bit r, input bit c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        ovf_clr   = c;
        #1;
        compare_all(tag);
        @(posedge clk);
        model_edge(v, d, r, c);
        #1;
    endtask

    // Asynchronous reset pulse taken away from the clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_entry();
        #1;
        q.delete();
        m_beat = 0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        compare_all({tag, ".async"});
        @(posedge clk);
        @(posedge clk);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        compare_all({tag, ".post"});
    endtask

    initial begin
        logic [IN_W-1:0] ent;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        m_beat = 0; m_ovf = 1'b0; m_cnt = 0;
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Single entry with lanes 0x01..0x12.
        for (int i = 0; i < MAC_OUT_NUM; i++) ent[i*DATA_WIDTH +: DATA_WIDTH] = 8'(i + 1);
        step("single.push", 1'b1, ent, 1'b1, 1'b0);
        check("single.b0", IN_W'(out_data), IN_W'(72'h090807060504030201));
        check("single.b0last", IN_W'(out_last), '0);
        check("single.lvl1", IN_W'(level), IN_W'(1));
        step("single.beat0", 1'b0, '0, 1'b1, 1'b0);
        check("single.b1", IN_W'(out_data), IN_W'(72'h1211100F0E0D0C0B0A));
        check("single.b1last", IN_W'(out_last), IN_W'(1));
        step("single.beat1", 1'b0, '0, 1'b1, 1'b0);
        check("single.cnt", IN_W'(entry_cnt), IN_W'(1));
        check("single.lvl0", IN_W'(level), '0);

        // Five back-to-back pushes with the sink stalled: fifth is dropped.
        for (int i = 0; i < 5; i++) step("fill5", 1'b1, rand_entry(), 1'b0, 1'b0);
        check("fill5.lvl", IN_W'(level), IN_W'(4));
        check("fill5.ovf", IN_W'(overflow), IN_W'(1));
        for (int i = 0; i < 9; i++) step("drain4", 1'b0, '0, 1'b1, 1'b0);
        check("drain4.cnt", IN_W'(entry_cnt), IN_W'(5));

        // Drop and clear together keep the flag; a lone clear removes it.
        for (int i = 0; i < 5; i++) step("ovf.fill", 1'b1, rand_entry(), 1'b0, 1'b0);
        step("ovf.both", 1'b1, rand_entry(), 1'b0, 1'b1);
        check("ovf.kept", IN_W'(overflow), IN_W'(1));
        step("ovf.clr", 1'b0, '0, 1'b0, 1'b1);
        check("ovf.cleared", IN_W'(overflow), '0);

        // Full FIFO, push coincident with the final-beat pop is accepted.
        step("full.b0", 1'b0, '0, 1'b1, 1'b0);
        step("full.pp", 1'b1, rand_entry(), 1'b1, 1'b0);
        check("full.lvl", IN_W'(level), IN_W'(4));
        check("full.ovf", IN_W'(overflow), '0);
        for (int i = 0; i < 9; i++) step("full.drain", 1'b0, '0, 1'b1, 1'b0);

        // Sink ready toggling every cycle while entries stream in.
        for (int i = 0; i < 24; i++) step("toggle", (i % 3) == 0, rand_entry(), (i % 2) == 0, 1'b0);
        for (int i = 0; i < 10; i++) step("toggle.drain", 1'b0, '0, 1'b1, 1'b0);

        // Sustained one entry per two cycles with ready high never drops.
        for (int i = 0; i < 30; i++) step("rate", (i % 2) == 0, rand_entry(), 1'b1, 1'b0);
        check("rate.ovf", IN_W'(overflow), '0);
        for (int i = 0; i < 4; i++) step("rate.drain", 1'b0, '0, 1'b1, 1'b0);

        // Reset with a partial entry (sel=1) and two entries stored.
        step("mid.p0", 1'b1, rand_entry(), 1'b0, 1'b0);
        step("mid.p1", 1'b1, rand_entry(), 1'b0, 1'b0);
        step("mid.b0", 1'b0, '0, 1'b1, 1'b0);
        check("mid.sel", IN_W'(out_last), IN_W'(1));
        check("mid.lvl", IN_W'(level), IN_W'(2));
        do_reset("mid.rst");
        step("mid.push", 1'b1, rand_entry(), 1'b0, 1'b0);
        check("mid.first", IN_W'(out_last), '0);
        step("mid.stall", 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("mid.drain", 1'b0, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 99) < 55), rand_entry(),
                 ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 10));
        end
        for (int i = 0; i < 10; i++) step("final.drain", 1'b0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
